tc_tile_sched: RTL and testbench

Tile-loop scheduler for the tensor-core datapath. After a `start` pulse it walks the operand tiles in M-inner, K-middle, N-outer order and presents each tile's pointers to the tile-select/array stage over a valid/ready handshake. It tracks each issued tile through the fixed array latency and emits a matching writeback strobe with row/column and accumulate-control flags for the partial-sum buffer. It pulses `done` once the last result has drained.

---
 rtl/tc_tile_sched.sv | 156 +++++++++++++++
 tb/tb_tc_tile_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc_tile_sched.sv
// Tile-loop scheduler: walks M-inner/K-middle/N-outer tiles, issues them
// over valid/ready and tracks them through the fixed-latency array.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a job (only sampled while idle)
//   busy, done          job in progress / one-cycle end-of-job pulse
//   issue_valid/ready   tile handshake, issue_m/k/n tile origin
//   wb_valid            result of an issued tile leaves the array now
//   wb_row/col          m / n origin of that result
//   wb_first/wb_last    psum overwrite / psum final flags
module tc_tile_sched #(
  parameter int M      = 32,
  parameter int N      = 32,
  parameter int K      = 32,
  parameter int TILE_M = 4,
  parameter int TILE_K = 8,
  parameter int TILE_N = 4,
  parameter int PW     = 6,
  parameter int LAT    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [PW-1:0] issue_m,
  output logic [PW-1:0] issue_k,
  output logic [PW-1:0] issue_n,
  output logic          wb_valid,
  output logic [PW-1:0] wb_row,
  output logic [PW-1:0] wb_col,
  output logic          wb_first,
  output logic          wb_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [PW-1:0] M_END = PW'(M - TILE_M);
  localparam logic [PW-1:0] K_END = PW'(K - TILE_K);
  localparam logic [PW-1:0] N_END = PW'(N - TILE_N);

  state_t        state, state_nx;
  logic [PW-1:0] pm, pk, pn;
  logic [PW-1:0] pm_nx, pk_nx, pn_nx;
  logic          fire;
  logic          pend;

  logic [LAT-1:0] dv, df, dl;
  logic [LAT-1:0] dv_sh;
  logic [PW-1:0]  dm [LAT];
  logic [PW-1:0]  dn [LAT];

  assign fire = (state == S_RUN) & issue_ready;

  // Entries that survive the next shift; the last stage is leaving
  // this cycle, so DONE lands exactly one cycle after the final result.
  assign dv_sh = dv << 1;
  assign pend  = |dv_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pm    <= '0;
      pk    <= '0;
      pn    <= '0;
    end else begin
      state <= state_nx;
      pm    <= pm_nx;
      pk    <= pk_nx;
      pn    <= pn_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pm_nx    = pm;
    pk_nx    = pk;
    pn_nx    = pn;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          if (pm == M_END && pk == K_END && pn == N_END) begin
            state_nx = S_DRAIN;
            pm_nx    = '0;
            pk_nx    = '0;
            pn_nx    = '0;
          end else if (pm != M_END) begin
            pm_nx = pm + PW'(TILE_M);
          end else begin
            pm_nx = '0;
            if (pk != K_END) begin
              pk_nx = pk + PW'(TILE_K);
            end else begin
              pk_nx = '0;
              pn_nx = pn + PW'(TILE_N);
            end
          end
        end
      end
      S_DRAIN: begin
        if (!pend) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Non-stallable array: the line shifts every cycle. Idle slots carry
  // zeros so the wb_* fields are already 0 whenever wb_valid is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      dv <= '0;
      df <= '0;
      dl <= '0;
      for (int i = 0; i < LAT; i++) begin
        dm[i] <= '0;
        dn[i] <= '0;
      end
    end else begin
      dv    <= (dv << 1) | LAT'(fire);
      df    <= (df << 1) | LAT'(fire && pk == '0);
      dl    <= (dl << 1) | LAT'(fire && pk == K_END);
      dm[0] <= fire ? pm : '0;
      dn[0] <= fire ? pn : '0;
      for (int i = 1; i < LAT; i++) begin
        dm[i] <= dm[i-1];
        dn[i] <= dn[i-1];
      end
    end
  end

  assign busy        = (state == S_RUN) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign issue_valid = (state == S_RUN);
  assign issue_m     = pm;
  assign issue_k     = pk;
  assign issue_n     = pn;
  assign wb_valid    = dv[LAT-1];
  assign wb_row      = dm[LAT-1];
  assign wb_col      = dn[LAT-1];
  assign wb_first    = df[LAT-1];
  assign wb_last     = dl[LAT-1];

endmodule

// File: tb/tb_tc_tile_sched.sv
// Testbench for tc_tile_sched: two instances (K=16 and K=8) driven with
// shared directed and random stimulus, compared against a tile-list model.
module tb_tc_tile_sched;

  localparam int PW  = 6;
  localparam int LAT = 6;
  localparam int MM  = 8;
  localparam int NN  = 8;
  localparam int TM  = 4;
  localparam int TK  = 8;
  localparam int TN  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;

  logic [1:0]    busy, done, iv, wv, wf, wl;
  logic [PW-1:0] i_m [2];
  logic [PW-1:0] i_k [2];
  logic [PW-1:0] i_n [2];
  logic [PW-1:0] w_r [2];
  logic [PW-1:0] w_c [2];

  always #5 clk = ~clk;

  tc_tile_sched #(
    .M(MM), .N(NN), .K(16), .TILE_M(TM), .TILE_K(TK), .TILE_N(TN),
    .PW(PW), .LAT(LAT)
  ) u0 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy[0]), .done(done[0]),
    .issue_valid(iv[0]), .issue_ready(ready),
    .issue_m(i_m[0]), .issue_k(i_k[0]), .issue_n(i_n[0]),
    .wb_valid(wv[0]), .wb_row(w_r[0]), .wb_col(w_c[0]),
    .wb_first(wf[0]), .wb_last(wl[0])
  );

  tc_tile_sched #(
    .M(MM), .N(NN), .K(8), .TILE_M(TM), .TILE_K(TK), .TILE_N(TN),
    .PW(PW), .LAT(LAT)
  ) u1 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy[1]), .done(done[1]),
    .issue_valid(iv[1]), .issue_ready(ready),
    .issue_m(i_m[1]), .issue_k(i_k[1]), .issue_n(i_n[1]),
    .wb_valid(wv[1]), .wb_row(w_r[1]), .wb_col(w_c[1]),
    .wb_first(wf[1]), .wb_last(wl[1])
  );

  int errors = 0;
  int checks = 0;
  int t = 0;

  int kk [2] = '{16, 8};
  int run [2];
  int idx [2];
  int dcyc [2];
  int wbm [int];

  int wbcnt [2];
  int dncnt [2];
  int dn_t [2];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  function automatic int total(input int d);
    return (MM / TM) * (kk[d] / TK) * (NN / TN);
  endfunction

  function automatic int tm_of(input int i);
    return (i % (MM / TM)) * TM;
  endfunction

  function automatic int tk_of(input int d, input int i);
    return ((i / (MM / TM)) % (kk[d] / TK)) * TK;
  endfunction

  function automatic int tn_of(input int d, input int i);
    return (i / ((MM / TM) * (kk[d] / TK))) * TN;
  endfunction

  function automatic int key(input int d, input int c);
    return d * 1000000 + c;
  endfunction

  task automatic compare(input int d);
    int em, ek, en, ev, val;
    em = 0; ek = 0; en = 0; ev = 0; val = 0;
    if (run[d] != 0) begin
      em = tm_of(idx[d]);
      ek = tk_of(d, idx[d]);
      en = tn_of(d, idx[d]);
    end
    if (wbm.exists(key(d, t))) begin
      ev  = 1;
      val = wbm[key(d, t)];
    end
    check($sformatf("busy%0d", d), int'(busy[d]),
          int'(run[d] != 0 || t < dcyc[d]));
    check($sformatf("done%0d", d), int'(done[d]), int'(t == dcyc[d]));
    check($sformatf("issue_valid%0d", d), int'(iv[d]), run[d]);
    check($sformatf("issue_m%0d", d), int'(i_m[d]), em);
    check($sformatf("issue_k%0d", d), int'(i_k[d]), ek);
    check($sformatf("issue_n%0d", d), int'(i_n[d]), en);
    check($sformatf("wb_valid%0d", d), int'(wv[d]), ev);
    check($sformatf("wb_row%0d", d), int'(w_r[d]), (val >> 6) & 63);
    check($sformatf("wb_col%0d", d), int'(w_c[d]), val & 63);
    check($sformatf("wb_first%0d", d), int'(wf[d]), (val >> 13) & 1);
    check($sformatf("wb_last%0d", d), int'(wl[d]), (val >> 12) & 1);
    if (wv[d]) wbcnt[d]++;
    if (done[d]) begin
      dncnt[d]++;
      dn_t[d] = t;
    end
  endtask

  task automatic model_edge(input int d, input logic st,
                            input logic rd, input logic rs);
    int k, v;
    if (rs) begin
      run[d]  = 0;
      dcyc[d] = -1;
      for (int j = 1; j <= LAT; j++)
        if (wbm.exists(key(d, t + j))) wbm.delete(key(d, t + j));
    end else if (run[d] != 0) begin
      if (rd) begin
        k = tk_of(d, idx[d]);
        v = (tm_of(idx[d]) << 6) | tn_of(d, idx[d]);
        if (k == 0) v |= 1 << 13;
        if (k == kk[d] - TK) v |= 1 << 12;
        wbm[key(d, t + LAT)] = v;
        idx[d]++;
        if (idx[d] == total(d)) begin
          run[d]  = 0;
          dcyc[d] = t + LAT + 1;
        end
      end
    end else if (t > dcyc[d] && st) begin
      run[d] = 1;
      idx[d] = 0;
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic rs,
                      input bit chk_en);
    @(negedge clk);
    if (chk_en) begin
      compare(0);
      compare(1);
    end
    start = st;
    ready = rd;
    reset = rs;
    model_edge(0, st, rd, rs);
    model_edge(1, st, rd, rs);
    t++;
  endtask

  task automatic seg_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      wbcnt[d] = 0;
      dncnt[d] = 0;
      dn_t[d]  = -1;
    end
  endtask

  initial begin
    int t0;
    for (int d = 0; d < 2; d++) begin
      run[d] = 0; idx[d] = 0; dcyc[d] = -1;
    end
    start = 1'b0;
    ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Full job, always ready, with a second start while busy.
    seg_reset();
    t0 = t;
    for (int i = 0; i < 30; i++)
      step(i == 0 || i == 5, 1'b1, 1'b0, 1'b1);
    check("s1_wb_count0", wbcnt[0], 8);
    check("s1_done_count0", dncnt[0], 1);
    check("s1_done_cycle0", dn_t[0] - t0, 15);
    check("s6_wb_count1", wbcnt[1], 4);
    check("s6_done_cycle1", dn_t[1] - t0, 11);

    // Backpressure on cycles 2..4.
    seg_reset();
    t0 = t;
    for (int i = 0; i < 30; i++)
      step(i == 0, !(i >= 2 && i <= 4), 1'b0, 1'b1);
    check("s2_done_cycle0", dn_t[0] - t0, 18);
    check("s2_wb_count0", wbcnt[0], 8);

    // Reset mid-job, then restart.
    seg_reset();
    t0 = t;
    for (int i = 0; i < 40; i++)
      step(i == 0 || i == 12, 1'b1, i == 9, 1'b1);
    check("s4_done_count0", dncnt[0], 1);
    check("s4_done_cycle0", dn_t[0] - t0, 27);

    // Start held high: back-to-back jobs.
    seg_reset();
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0, 1'b1);

    // Random start / ready / reset traffic.
    seg_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 299) == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
